// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Data-memory access stage between the multicycle RISC-V datapath and a 64-bit
// data memory. It turns one core load/store request into dword-aligned memory
// transactions:
//   - loads        : one read, result shifted and sign/zero-extended
//   - sd           : one full-dword write
//   - sb / sh / sw : read-modify-write (read the dword, merge, write it back)
// Misaligned accesses and illegal func3 encodings complete with fault=1 and
// never touch memory.
//
// Handshakes:
//   Core side   : req is sampled only while the unit is idle (busy=0); a req
//                 seen while busy is dropped, not queued. Completion is a
//                 one-cycle done pulse; fault qualifies done; rdata holds the
//                 last load result until the next completing load.
//   Memory side : mem_req/mem_we/mem_addr/mem_wdata are registered and stay
//                 stable while mem_req=1. A transfer completes on the rising
//                 edge where mem_req=1 and mem_ack=1. mem_rdata is only
//                 looked at on that edge. mem_ack outside RD/WR is ignored.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   req        in   core request
//   we         in   1 = store, 0 = load
//   func3      in   RISC-V funct3 (size in [1:0], unsigned/illegal in [2])
//   addr       in   byte address
//   wdata      in   store data (low-order bytes used)
//   busy       out  high whenever the FSM is not in IDLE
//   done       out  one-cycle completion pulse
//   rdata      out  extended load result
//   fault      out  misaligned/illegal flag, valid with done
//   mem_req    out  memory request, held until mem_ack
//   mem_we     out  memory write enable
//   mem_addr   out  dword-aligned memory address
//   mem_wdata  out  dword to write
//   mem_rdata  in   memory read data, valid with mem_ack
//   mem_ack    in   memory completes the current request
//   dbgState   out  current FSM state (0 IDLE, 1 RD, 2 WR, 3 DONE)
// -----------------------------------------------------------------------------
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [63:0] rdata,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT       state;

    // Request fields latched when the request is accepted.
    logic        weQ;
    logic [2:0]  func3Q;
    logic [2:0]  offQ;
    logic [63:0] wdataQ;

    // Request decode, evaluated on the live inputs while idle.
    logic        misaligned;
    logic        illegal;
    logic        isSd;

    // Load extraction and store merge, evaluated on latched fields.
    logic [63:0] shiftedRd;
    logic [63:0] loadData;
    logic [7:0]  sizeMask;
    logic [7:0]  laneMask;
    logic [63:0] shiftedWd;
    logic [63:0] mergedData;

    assign dbgState = state;

    always_comb begin
        misaligned = 1'b0;
        case (func3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = |addr[2:0];
        endcase
        illegal = we ? func3[2] : (func3 == 3'b111);
        isSd    = we && (func3[1:0] == 2'b11);
    end

    // Load: bring the addressed lane down to bit 0, then extend.
    // func3[2]=1 selects zero extension; ld needs no extension at all.
    always_comb begin
        shiftedRd = mem_rdata >> {offQ, 3'b000};
        loadData  = shiftedRd;
        case (func3Q[1:0])
            2'b00:   loadData = func3Q[2] ? {56'b0, shiftedRd[7:0]}
                                          : {{56{shiftedRd[7]}}, shiftedRd[7:0]};
            2'b01:   loadData = func3Q[2] ? {48'b0, shiftedRd[15:0]}
                                          : {{48{shiftedRd[15]}}, shiftedRd[15:0]};
            2'b10:   loadData = func3Q[2] ? {32'b0, shiftedRd[31:0]}
                                          : {{32{shiftedRd[31]}}, shiftedRd[31:0]};
            default: loadData = shiftedRd;
        endcase
    end

    // Store merge: store bytes move up to the addressed lanes; lanes outside
    // the access keep the value just read from memory. Alignment is already
    // guaranteed, so the shifted lane mask never runs past lane 7.
    always_comb begin
        sizeMask = 8'hFF;
        case (func3Q[1:0])
            2'b00:   sizeMask = 8'h01;
            2'b01:   sizeMask = 8'h03;
            2'b10:   sizeMask = 8'h0F;
            default: sizeMask = 8'hFF;
        endcase
        laneMask   = sizeMask << offQ;
        shiftedWd  = wdataQ << {offQ, 3'b000};
        mergedData = mem_rdata;
        for (int k = 0; k < 8; k++) begin
            if (laneMask[k]) begin
                mergedData[8*k +: 8] = shiftedWd[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            rdata     <= 64'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 64'b0;
            mem_wdata <= 64'b0;
            weQ       <= 1'b0;
            func3Q    <= 3'b0;
            offQ      <= 3'b0;
            wdataQ    <= 64'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        weQ    <= we;
                        func3Q <= func3;
                        offQ   <= addr[2:0];
                        wdataQ <= wdata;
                        busy   <= 1'b1;
                        if (misaligned || illegal) begin
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else if (isSd) begin
                            state     <= WR;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= {addr[63:3], 3'b000};
                            mem_wdata <= wdata;
                        end else begin
                            // Loads and sub-dword stores both start with a read.
                            state    <= RD;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {addr[63:3], 3'b000};
                        end
                    end
                end

                RD: begin
                    if (mem_ack) begin
                        if (weQ) begin
                            // mem_req stays high: the write follows directly.
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= mergedData;
                        end else begin
                            state   <= DONE;
                            mem_req <= 1'b0;
                            done    <= 1'b1;
                            rdata   <= loadData;
                        end
                    end
                end

                WR: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. A behavioural memory with a programmable
// ack delay answers the memory port; every memory transaction the stimulus
// expects ({we, addr, data}) is queued up front and popped as the memory sees
// it. Load results, fault flags and completion latency are checked at done.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  func3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic [63:0] rdata;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  dbgState;

    int assertCnt = 0;
    int failCnt   = 0;

    // Expected memory transactions: {we, addr, data}; data checked on writes.
    logic [128:0] expTxnQ[$];
    logic [63:0]  memArr[logic [63:0]];
    int           ackDelay = 0;
    int           waitCnt  = 0;
    logic [128:0] capTxn;
    logic [63:0]  lastRd = 64'b0;

    load_store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .func3     (func3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dbgState  (dbgState)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        assertCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    // Looks at the registered memory port 1 time unit after each edge and
    // raises mem_ack after ackDelay wait cycles; the DUT takes it on the next
    // edge. Port stability is checked on every wait cycle.
    always @(posedge clk) begin
        #1;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (waitCnt == 0) begin
                capTxn = {mem_we, mem_addr, mem_wdata};
            end else begin
                check("memPortStable", {mem_we, mem_addr, mem_wdata}, capTxn);
            end
            if (waitCnt >= ackDelay) begin
                if (expTxnQ.size() == 0) begin
                    check("unexpectedMemTxn", {mem_we, mem_addr, mem_wdata}, 129'b0);
                end else begin
                    logic [128:0] e;
                    e = expTxnQ.pop_front();
                    check("memTxnWeAddr", {64'b0, mem_we, mem_addr}, {64'b0, e[128:64]});
                    if (mem_we) check("memTxnWdata", {65'b0, mem_wdata}, {65'b0, e[63:0]});
                end
                if (mem_we) memArr[mem_addr] = mem_wdata;
                else        mem_rdata = memArr.exists(mem_addr) ? memArr[mem_addr] : 64'b0;
                mem_ack = 1'b1;
                waitCnt = 0;
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
    end

    // ---------------- driver ----------------
    // Issues one request and follows it to done. Latency is counted in clock
    // edges from the edge that samples req. For a load without fault the
    // returned value must equal expRd; otherwise rdata must be unchanged.
    task automatic doAccess(input logic isStore, input logic [2:0] f3,
                            input logic [63:0] a, input logic [63:0] wd,
                            input int expLat, input logic expFault,
                            input logic [63:0] expRd, input bit pulseBusy,
                            input string tag);
        int lat;
        @(negedge clk);
        req = 1'b1; we = isStore; func3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            if (pulseBusy && lat == 2) begin
                // A load request while busy; must be dropped.
                req = 1'b1; we = 1'b0; func3 = 3'b011; addr = 64'h20;
            end else begin
                req = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        req = 1'b0;
        if (!isStore && !expFault) lastRd = expRd;
        check({tag, ".done"},    {128'b0, done},  {128'b0, 1'b1});
        check({tag, ".latency"}, {97'b0, lat},    {97'b0, expLat});
        check({tag, ".fault"},   {128'b0, fault}, {128'b0, expFault});
        check({tag, ".rdata"},   {65'b0, rdata},  {65'b0, lastRd});
        @(posedge clk);
        #1;
        check({tag, ".idleAfter"}, {127'b0, busy, done}, 129'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        reset = 1'b0; req = 1'b0; we = 1'b0; func3 = 3'b0;
        addr = 64'b0; wdata = 64'b0; mem_rdata = 64'b0; mem_ack = 1'b0;
        memArr[64'h10] = 64'h8877665544332211;
        memArr[64'h18] = 64'h0;
        memArr[64'h20] = 64'h0;

        repeat (3) @(posedge clk);
        #1;
        check("resetCtrl", {123'b0, busy, done, fault, mem_req, mem_we, 1'b0},
              129'b0);
        check("resetState", {127'b0, dbgState}, 129'b0);
        check("resetRdata", {65'b0, rdata}, 129'b0);
        check("resetMemAddr", {65'b0, mem_addr}, 129'b0);
        check("resetMemWdata", {65'b0, mem_wdata}, 129'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // 1. loads from dword 0x10
        expTxnQ.push_back({1'b0, 64'h10, 64'h0});
        doAccess(0, 3'b000, 64'h17, 64'h0, 2, 0, 64'hFFFFFFFFFFFFFF88, 0, "lb17");
        expTxnQ.push_back({1'b0, 64'h10, 64'h0});
        doAccess(0, 3'b100, 64'h17, 64'h0, 2, 0, 64'h0000000000000088, 0, "lbu17");
        expTxnQ.push_back({1'b0, 64'h10, 64'h0});
        doAccess(0, 3'b001, 64'h16, 64'h0, 2, 0, 64'hFFFFFFFFFFFF8877, 0, "lh16");
        expTxnQ.push_back({1'b0, 64'h10, 64'h0});
        doAccess(0, 3'b110, 64'h14, 64'h0, 2, 0, 64'h0000000088776655, 0, "lwu14");

        // 2. sub-dword stores (read-modify-write)
        expTxnQ.push_back({1'b0, 64'h10, 64'h0});
        expTxnQ.push_back({1'b1, 64'h10, 64'hAABBCCDD44332211});
        doAccess(1, 3'b010, 64'h14, 64'hAABBCCDD, 3, 0, 64'h0, 0, "sw14");
        memArr[64'h10] = 64'h8877665544332211;
        expTxnQ.push_back({1'b0, 64'h10, 64'h0});
        expTxnQ.push_back({1'b1, 64'h10, 64'h887766554433EE11});
        doAccess(1, 3'b000, 64'h11, 64'hEE, 3, 0, 64'h0, 0, "sb11");

        // 3. sd then ld
        expTxnQ.push_back({1'b1, 64'h20, 64'h0123456789ABCDEF});
        doAccess(1, 3'b011, 64'h20, 64'h0123456789ABCDEF, 2, 0, 64'h0, 0, "sd20");
        expTxnQ.push_back({1'b0, 64'h20, 64'h0});
        doAccess(0, 3'b011, 64'h20, 64'h0, 2, 0, 64'h0123456789ABCDEF, 0, "ld20");

        // 4. faults: no memory traffic expected
        doAccess(0, 3'b010, 64'h12, 64'h0, 1, 1, 64'h0, 0, "lw12");
        doAccess(1, 3'b001, 64'h13, 64'h55, 1, 1, 64'h0, 0, "sh13");
        doAccess(0, 3'b011, 64'h24, 64'h0, 1, 1, 64'h0, 0, "ld24");
        doAccess(0, 3'b111, 64'h10, 64'h0, 1, 1, 64'h0, 0, "load111");
        doAccess(1, 3'b100, 64'h10, 64'h0, 1, 1, 64'h0, 0, "storeF3hi");

        // 5. delayed acks on sb, with req pulses while busy
        ackDelay = 3;
        expTxnQ.push_back({1'b0, 64'h10, 64'h0});
        expTxnQ.push_back({1'b1, 64'h10, 64'h887766555A33EE11});
        doAccess(1, 3'b000, 64'h13, 64'h5A, 9, 0, 64'h0, 1, "sb13wait");

        // 6. reset during the WR wait of sw
        ackDelay = 5;
        expTxnQ.push_back({1'b0, 64'h18, 64'h0});
        @(negedge clk);
        req = 1'b1; we = 1'b1; func3 = 3'b010; addr = 64'h18; wdata = 64'h12345678;
        @(posedge clk);
        #1;
        req = 1'b0;
        guard = 0;
        while (!(mem_req && mem_we) && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("swReachedWr", {127'b0, mem_req, mem_we}, {127'b0, 2'b11});
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midResetCtrl", {126'b0, busy, mem_req, done}, 129'b0);
        check("midResetState", {127'b0, dbgState}, 129'b0);
        lastRd = 64'b0;
        @(negedge clk);
        reset = 1'b1;
        ackDelay = 0;
        repeat (2) @(posedge clk);
        expTxnQ.push_back({1'b0, 64'h10, 64'h0});
        doAccess(0, 3'b000, 64'h11, 64'h0, 2, 0, 64'hFFFFFFFFFFFFFFEE, 0, "lbAfterReset");

        repeat (3) @(posedge clk);
        #1;
        check("txnQueueDrained", {97'b0, expTxnQ.size()}, 129'b0);
        check("memAt18Untouched", {65'b0, memArr[64'h18]}, 129'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
